tx_channel_arbiter: RTL and testbench
=====================================

# tx_channel_arbiter

Sequencer and arbiter for the byte-wide host TX channel. It shares the single TX path to the USB/FTDI interface between several load/ack/empty readout sources, such as the configuration shift register and the sample buffer readers. For each source request it issues the load pulse, streams every byte with a per-byte ack, detects end-of-burst through the source's empty flag, and then grants the next source in round-robin order.

## Interface
- NUM_SRC, 4: number of readout sources (2..8)
- TX_WIDTH, 8: byte width of TX channel and source data
- MAX_WAIT, 4: cycles allowed for a loaded source to drop empty before the burst is aborted (1..255)
- HDR_BASE, 8'hA0: header byte base value; header = HDR_BASE + source index (used only with HEADER_EN)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- src_rqst  in  NUM_SRC  per-source readout request; any 1-cycle pulse sets that source's pending bit
- src_load  out  NUM_SRC  one-hot, 1-cycle pulse telling the granted source to capture its data
- src_data  in  NUM_SRC*TX_WIDTH  current low byte of each source; source i occupies bits [i*TX_WIDTH +: TX_WIDTH]
- src_empty  in  NUM_SRC  source has no byte left (1 = empty)
- src_ack  out  NUM_SRC  one-hot, 1-cycle byte-consumed strobe to the granted source
- tx_data  out  TX_WIDTH  byte offered to the TX channel
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  TX channel accepts the byte this cycle
- grant  out  NUM_SRC  one-hot owner of the channel; 0 when idle
- burst_done  out  1  1-cycle pulse when a burst completes normally
- abort  out  1  1-cycle pulse when a burst is abandoned on MAX_WAIT timeout

## Operation
- pending[NUM_SRC] register:
  - bit i set by src_rqst[i];
  - bit i cleared in the LOAD cycle of source i;
  - if set and clear occur in the same cycle, set wins.
- Round-robin pointer ptr (reset 0):
  - in IDLE, the first pending index at or after ptr, modulo NUM_SRC, is granted;
  - on burst end (done or abort), ptr <= g+1 mod NUM_SRC.
- States (3-bit register): IDLE, LOAD, WAIT, HDR, SEND, SETTLE.
  - IDLE: grant=0. If any pending, latch g and go to LOAD.
  - LOAD: src_load[g]=1 for exactly this cycle; clear pending[g]; wait counter <= 0; go to WAIT.
  - WAIT:
    - src_empty[g]==0: go to HDR if HEADER_EN, else SEND;
    - otherwise increment the counter; when it reaches MAX_WAIT, pulse abort, go to IDLE.
  - HDR: tx_valid=1, tx_data=HDR_BASE+g. On tx_ready go to SEND. No src_ack.
  - SEND:
    - tx_valid=1, tx_data=src_data[g];
    - on tx_ready: src_ack[g]=1 this cycle, go to SETTLE;
    - if src_empty[g]==1 on entry: tx_valid=0, pulse burst_done, go to IDLE.
  - SETTLE: tx_valid=0 for one cycle so the source can shift. Then:
    - src_empty[g]==1: pulse burst_done, go to IDLE;
    - otherwise go to SEND.
- tx_valid, tx_data, src_ack are combinational from state, g and tx_ready. All other outputs are registered.
- While tx_ready=0, tx_valid and tx_data hold stable, and src_ack stays 0.

## Timing
- All outputs are 0 while rst is low: grant=0, src_load=0, src_ack=0, tx_valid=0, tx_data=0, burst_done=0, abort=0.
- Reset mid-burst returns to IDLE, clears pending and sets ptr=0. The source must be reset by the same rst.
- Latency:
  - src_rqst at cycle N gives pending at N+1, LOAD (src_load high) at N+2;
  - a source that drops empty one cycle after load is seen in WAIT at N+3;
  - first byte tx_valid at N+4, or HDR byte at N+4 with data at N+5 when HEADER_EN.
- Throughput: at most one source byte per 2 cycles (SEND + SETTLE) with tx_ready held high.
- A request for the currently granted source during its burst is kept pending and served after the other pending sources.

## Configuration
- HEADER_EN defined: one header byte HDR_BASE+g is sent before each burst's first data byte. The header consumes no src_ack. It is not sent on abort.
- HEADER_EN undefined:
  - the HDR state is unreachable;
  - WAIT goes directly to SEND;
  - the stream contains source bytes only.

## Test plan
- Single burst: NUM_SRC=2, source 0 model holds 0x11,0x22,0x33 (empty drops 1 cycle after load, rises 1 cycle after the 3rd ack), tx_ready=1 -> tx bytes 0x11,0x22,0x33, exactly 3 src_ack[0] pulses, one src_load[0], burst_done once, grant returns to 0.
- Back-pressure: same source, tx_ready low for 5 cycles during byte 0x22 -> tx_data holds 0x22 with tx_valid=1, no src_ack until tx_ready rises, byte order unchanged.
- Round robin: src_rqst=2'b11 in one cycle -> source 0 burst fully sent, then source 1. Source 0 re-requests during its own burst -> order is 0,1,0.
- Timeout: source 1 keeps src_empty=1 after load, MAX_WAIT=4 -> abort pulse 4 cycles after WAIT entry, no tx_valid, ptr advances to 0.
- Reset mid-burst: rst low after the first byte of 3 -> all outputs 0 within the reset cycle, pending cleared. After release with no src_rqst, stays IDLE.
- HEADER_EN build: source 1 burst 0x11,0x22 -> stream 0xA1,0x11,0x22, with exactly 2 src_ack[1] pulses.

Source files
------------

// File: rtl/tx_channel_arbiter.sv
// Round-robin sequencer of load/ack/empty readout sources onto one byte-wide TX channel (request to load in 2 cycles).
// tx_valid/tx_data hold while tx_ready is low; define HEADER_EN to prefix each burst with header byte HDR_BASE+source.
module tx_channel_arbiter #(
  parameter int                  NUM_SRC  = 4,
  parameter int                  TX_WIDTH = 8,
  parameter int                  MAX_WAIT = 4,
  parameter logic [TX_WIDTH-1:0] HDR_BASE = TX_WIDTH'(8'hA0)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_rqst,
  output logic [NUM_SRC-1:0]           src_load,
  input  logic [NUM_SRC*TX_WIDTH-1:0]  src_data,
  input  logic [NUM_SRC-1:0]           src_empty,
  output logic [NUM_SRC-1:0]           src_ack,
  output logic [TX_WIDTH-1:0]          tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [NUM_SRC-1:0]           grant,
  output logic                         burst_done,
  output logic                         abort
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    HDR    = 3'd3,
    SEND   = 3'd4,
    SETTLE = 3'd5
  } state_t;

  state_t               state;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   pick_oh;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        pick;
  logic [IW-1:0]        gidx_next;
  logic                 pick_vld;
  logic [7:0]           wait_cnt;
  logic [TX_WIDTH-1:0]  cur_data;
  logic                 cur_empty;

  // First pending source at or after ptr, wrapping around.
  always_comb begin
    int j;
    j        = 0;
    pick     = ptr;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!pick_vld && pending[IW'(j)]) begin
        pick     = IW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_oh   = NUM_SRC'(1) << pick;
  assign gidx_next = (gidx == IW'(NUM_SRC - 1)) ? '0 : gidx + IW'(1);

  always_comb begin
    cur_data  = '0;
    cur_empty = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gidx == IW'(i)) begin
        cur_data  = src_data[i*TX_WIDTH +: TX_WIDTH];
        cur_empty = src_empty[i];
      end
    end
  end

  // The ack only fires on an accepted byte, so a stalled channel leaves the source untouched.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    src_ack  = '0;
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BASE + TX_WIDTH'(gidx);
      end
      SEND: begin
        if (!cur_empty) begin
          tx_valid = 1'b1;
          tx_data  = cur_data;
          if (tx_ready) src_ack = grant;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= '0;
      ptr        <= '0;
      gidx       <= '0;
      grant      <= '0;
      src_load   <= '0;
      burst_done <= 1'b0;
      abort      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      src_load   <= '0;
      burst_done <= 1'b0;
      abort      <= 1'b0;
      // A new request arriving in the LOAD cycle survives the clear.
      pending    <= (pending & ~((state == LOAD) ? grant : '0)) | src_rqst;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gidx     <= pick;
            grant    <= pick_oh;
            src_load <= pick_oh;
            state    <= LOAD;
          end
        end
        LOAD: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (!cur_empty) begin
`ifdef HEADER_EN
            state <= HDR;
`else
            state <= SEND;
`endif
          end else if (({1'b0, wait_cnt} + 9'd1) == 9'(MAX_WAIT)) begin
            abort <= 1'b1;
            grant <= '0;
            ptr   <= gidx_next;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HDR: begin
          if (tx_ready) state <= SEND;
        end
        SEND: begin
          if (cur_empty) begin
            burst_done <= 1'b1;
            grant      <= '0;
            ptr        <= gidx_next;
            state      <= IDLE;
          end else if (tx_ready) begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cur_empty) begin
            burst_done <= 1'b1;
            grant      <= '0;
            ptr        <= gidx_next;
            state      <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Directed bench for tx_channel_arbiter with two modelled readout sources (NUM_SRC=2, MAX_WAIT=4).
module tb_tx_channel_arbiter;

  localparam int NS = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS-1:0]   src_rqst;
  logic [NS-1:0]   src_load;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0]   src_empty;
  logic [NS-1:0]   src_ack;
  logic [W-1:0]    tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [NS-1:0]   grant;
  logic            burst_done;
  logic            abort;

  always #5 clk = ~clk;

  tx_channel_arbiter #(
    .NUM_SRC (NS),
    .TX_WIDTH(W),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_rqst  (src_rqst),
    .src_load  (src_load),
    .src_data  (src_data),
    .src_empty (src_empty),
    .src_ack   (src_ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .burst_done(burst_done),
    .abort     (abort)
  );

  // Source model: load restarts the byte index, each ack advances it, empty once all bytes are consumed.
  logic [7:0]    mem [NS][4];
  int            len [NS];
  logic [NS-1:0] loaded;
  logic [1:0]    idx [NS];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded <= '0;
      for (int s = 0; s < NS; s++) idx[s] <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (src_load[s]) begin
          loaded[s] <= 1'b1;
          idx[s]    <= '0;
        end else if (src_ack[s]) begin
          idx[s] <= idx[s] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    src_empty = '1;
    src_data  = '0;
    for (int s = 0; s < NS; s++) begin
      src_empty[s]       = !loaded[s] || (int'(idx[s]) == len[s]);
      src_data[s*W +: W] = mem[s][idx[s]];
    end
  end

  // Recorders of everything the DUT emits.
  logic [7:0] txq [$];
  int         loadq [$];
  int         ack_cnt [NS] = '{default: 0};
  int         load_cnt [NS] = '{default: 0};
  int         done_cnt  = 0;
  int         abort_cnt = 0;
  int         valid_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (tx_valid) valid_cnt <= valid_cnt + 1;
      if (burst_done) done_cnt <= done_cnt + 1;
      if (abort) abort_cnt <= abort_cnt + 1;
      for (int s = 0; s < NS; s++) begin
        if (src_ack[s]) ack_cnt[s] <= ack_cnt[s] + 1;
        if (src_load[s]) begin
          load_cnt[s] <= load_cnt[s] + 1;
          loadq.push_back(s);
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int b_q, b_lq, b_done, b_abort, b_valid;
  int b_ack [NS];
  int b_load [NS];
  logic [7:0] exq [$];

`ifdef HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_q     = txq.size();
    b_lq    = loadq.size();
    b_done  = done_cnt;
    b_abort = abort_cnt;
    b_valid = valid_cnt;
    for (int s = 0; s < NS; s++) begin
      b_ack[s]  = ack_cnt[s];
      b_load[s] = load_cnt[s];
    end
    exq.delete();
  endtask

  task automatic exp_burst(input int s, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n);
    if (HDR_ON) exq.push_back(8'(8'hA0 + s));
    exq.push_back(b0);
    if (n > 1) exq.push_back(b1);
    if (n > 2) exq.push_back(b2);
  endtask

  task automatic chk_stream(input string tag);
    logic [7:0] obs;
    chk({tag, "_len"}, txq.size() - b_q, exq.size());
    foreach (exq[i]) begin
      obs = (b_q + i < txq.size()) ? txq[b_q + i] : 8'hxx;
      chk(tag, obs, exq[i]);
    end
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    src_rqst = m;
    @(negedge clk);
    src_rqst = '0;
  endtask

  task automatic wait_events(input int n, input int budget);
    int k;
    k = 0;
    while ((done_cnt + abort_cnt) < (b_done + b_abort + n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("burst_end_seen", (done_cnt + abort_cnt) >= (b_done + b_abort + n), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input logic [NS-1:0] g);
    int k;
    k = 0;
    while (grant !== g && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", grant, g);
  endtask

  initial begin
    int k;
    logic found;
    src_rqst = '0;
    tx_ready = 1'b1;
    mem[0] = '{8'h11, 8'h22, 8'h33, 8'h00};
    mem[1] = '{8'h44, 8'h55, 8'h00, 8'h00};
    len[0] = 3;
    len[1] = 2;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_load", src_load, 0);
    chk("rst_ack", src_ack, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_done_abort", {burst_done, abort}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single burst from source 0, with cycle-exact latency
    snap();
    pulse(2'b01);
    chk("lat_no_load_n1", src_load, 2'b00);
    @(negedge clk);
    chk("lat_load_n2", src_load, 2'b01);
    chk("lat_grant_n2", grant, 2'b01);
    @(negedge clk);
    chk("lat_wait_n3", tx_valid, 0);
    @(negedge clk);
`ifdef HEADER_EN
    chk("lat_hdr_valid_n4", tx_valid, 1);
    chk("lat_hdr_data_n4", tx_data, 8'hA0);
    chk("lat_hdr_noack_n4", src_ack, 2'b00);
    @(negedge clk);
    chk("lat_data_n5", tx_data, 8'h11);
    chk("lat_ack_n5", src_ack, 2'b01);
    @(negedge clk);
    chk("lat_settle_n6", tx_valid, 0);
`else
    chk("lat_valid_n4", tx_valid, 1);
    chk("lat_data_n4", tx_data, 8'h11);
    chk("lat_ack_n4", src_ack, 2'b01);
    @(negedge clk);
    chk("lat_settle_n5", tx_valid, 0);
    @(negedge clk);
    chk("lat_data_n6", tx_data, 8'h22);
`endif
    wait_events(1, 60);
    exp_burst(0, 8'h11, 8'h22, 8'h33, 3);
    chk_stream("single_stream");
    chk("single_acks", ack_cnt[0] - b_ack[0], 3);
    chk("single_loads", load_cnt[0] - b_load[0], 1);
    chk("single_done", done_cnt - b_done, 1);
    chk("single_grant_idle", grant, 0);

    // Back-pressure on byte 0x22
    snap();
    pulse(2'b01);
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk);
      k++;
      if (tx_valid && tx_data == 8'h22) found = 1'b1;
    end
    chk("bp_reach_22", found, 1);
    tx_ready = 1'b0;
    #1;
    chk("bp_ack_low", src_ack, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", tx_valid, 1);
      chk("bp_hold_data", tx_data, 8'h22);
      chk("bp_hold_ack", src_ack, 0);
    end
    tx_ready = 1'b1;
    #1;
    chk("bp_ack_resume", src_ack, 2'b01);
    wait_events(1, 60);
    exp_burst(0, 8'h11, 8'h22, 8'h33, 3);
    chk_stream("bp_stream");
    chk("bp_acks", ack_cnt[0] - b_ack[0], 3);

    // Timeout: source 1 never leaves empty
    len[1] = 0;
    snap();
    src_rqst = 2'b10;
    k = 0;
    do begin
      @(negedge clk);
      src_rqst = '0;
      k++;
    end while (!abort && k < 20);
    chk("to_abort_cycle", k, 7);
    @(negedge clk);
    chk("to_abort_one_cycle", abort, 0);
    chk("to_abort_cnt", abort_cnt - b_abort, 1);
    chk("to_no_valid", valid_cnt - b_valid, 0);
    chk("to_no_done", done_cnt - b_done, 0);
    chk("to_load1", load_cnt[1] - b_load[1], 1);
    chk("to_grant_idle", grant, 0);

    // Round robin with a re-request of source 0 during its own burst
    len[1] = 2;
    snap();
    pulse(2'b11);
    wait_grant(2'b01);
    pulse(2'b01);
    wait_events(3, 300);
    chk("rr_order0", (b_lq + 0 < loadq.size()) ? loadq[b_lq + 0] : -1, 0);
    chk("rr_order1", (b_lq + 1 < loadq.size()) ? loadq[b_lq + 1] : -1, 1);
    chk("rr_order2", (b_lq + 2 < loadq.size()) ? loadq[b_lq + 2] : -1, 0);
    chk("rr_done", done_cnt - b_done, 3);
    exp_burst(0, 8'h11, 8'h22, 8'h33, 3);
    exp_burst(1, 8'h44, 8'h55, 8'h00, 2);
    exp_burst(0, 8'h11, 8'h22, 8'h33, 3);
    chk_stream("rr_stream");

    // Reset in the middle of a burst, with source 1 pending
    snap();
    pulse(2'b01);
    wait_grant(2'b01);
    pulse(2'b10);
    k = 0;
    while (txq.size() <= b_q && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("mid_first_byte", txq.size() - b_q, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_load", src_load, 0);
    chk("mid_rst_ack", src_ack, 0);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_pulses", {burst_done, abort}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    chk("post_rst_no_load", (load_cnt[0] + load_cnt[1]) - (b_load[0] + b_load[1]), 0);
    chk("post_rst_no_valid", valid_cnt - b_valid, 0);
    chk("post_rst_grant", grant, 0);

    // Source 1 burst 0x11,0x22 (header 0xA1 when enabled)
    mem[1] = '{8'h11, 8'h22, 8'h00, 8'h00};
    snap();
    pulse(2'b10);
    wait_events(1, 60);
    exp_burst(1, 8'h11, 8'h22, 8'h00, 2);
    chk_stream("s1_stream");
    chk("s1_acks", ack_cnt[1] - b_ack[1], 2);
    chk("s1_no_ack0", ack_cnt[0] - b_ack[0], 0);
    chk("s1_done", done_cnt - b_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

endmodule
